fifo_status_detector: RTL and testbench

Parametrised, registered status generator for the cell-based FIFO. It reduces the per-cell empty flags into an occupancy count and empty, full, almost-empty and almost-full flags. The almost flags have programmable hysteresis, and sticky underflow/overflow error flags are driven from the read/write request strobes. It sits beside the FIFO cell array and feeds the producer and consumer flow-control logic.

---
 rtl/fifo_status_detector.sv | 126 ++++++++++++
 tb/tb_fifo_status_detector.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_status_detector.sv
// -----------------------------------------------------------------------------
// fifo_status_detector
//
// Registered status generator for the cell-based FIFO. It reduces the per-cell
// empty flags to an occupancy count and derives empty/full, hysteretic
// almost-empty/almost-full flags and sticky underflow/overflow error flags.
// The block only observes the FIFO; it never changes its contents.
//
// Parameters:
//   N_CELLS   number of FIFO cells (>= 2)
//   AE_THRESH almost-empty threshold (occupied cells)
//   AF_THRESH almost-full threshold (occupied cells)
//   HYST      hysteresis band in cells for both almost flags
//   CW        derived count width, $clog2(N_CELLS+1)
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   e_i            per-cell empty flags (1 = cell empty)
//   rd_req_i       consumer read attempt this cycle
//   wr_req_i       producer write attempt this cycle
//   clr_err_i      clears both sticky error flags (a same-edge set wins)
//   count          registered occupied-cell count
//   empty, full    registered count == 0 / count == N_CELLS
//   almost_empty   registered hysteretic low-level flag
//   almost_full    registered hysteretic high-level flag
//   underflow_err  sticky: read attempted while registered empty was 1
//   overflow_err   sticky: write attempted while registered full was 1
// -----------------------------------------------------------------------------
module fifo_status_detector #(
  parameter int  N_CELLS   = 16,
  parameter int  AE_THRESH = 2,
  parameter int  AF_THRESH = 14,
  parameter int  HYST      = 1,
  localparam int CW        = $clog2(N_CELLS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_CELLS-1:0] e_i,
  input  logic               rd_req_i,
  input  logic               wr_req_i,
  input  logic               clr_err_i,
  output logic [CW-1:0]      count,
  output logic               empty,
  output logic               full,
  output logic               almost_empty,
  output logic               almost_full,
  output logic               underflow_err,
  output logic               overflow_err
);

  // Threshold levels at count width. The legal parameter range keeps every
  // level inside 0..N_CELLS, so none of these casts drops a bit.
  localparam logic [CW-1:0] FULL_LVL   = CW'(N_CELLS);
  localparam logic [CW-1:0] AE_SET_LVL = CW'(AE_THRESH);
  localparam logic [CW-1:0] AE_CLR_LVL = CW'(AE_THRESH + HYST);
  localparam logic [CW-1:0] AF_SET_LVL = CW'(AF_THRESH);
  localparam logic [CW-1:0] AF_CLR_LVL = CW'(AF_THRESH - HYST);

  typedef enum logic {LOW_CLR  = 1'b0, LOW_SET  = 1'b1} low_state_t;
  typedef enum logic {HIGH_CLR = 1'b0, HIGH_SET = 1'b1} high_state_t;

  low_state_t  ae_state;
  high_state_t af_state;
  logic [CW-1:0] occ;

  // Stage 0: combinational popcount of occupied (zero) cells at full CW width.
  always_comb begin
    occ = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      if (!e_i[i]) occ = occ + CW'(1);
    end
  end

  // Stage 1: all status registers. Both FSMs look at this cycle's occ, and
  // the error flags look at the registered empty/full from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count         <= '0;
      empty         <= 1'b1;
      full          <= 1'b0;
      ae_state      <= LOW_SET;
      almost_empty  <= 1'b1;
      af_state      <= HIGH_CLR;
      almost_full   <= 1'b0;
      underflow_err <= 1'b0;
      overflow_err  <= 1'b0;
    end else begin
      count <= occ;
      empty <= (occ == '0);
      full  <= (occ == FULL_LVL);

      if (ae_state == LOW_CLR) begin
        if (occ <= AE_SET_LVL) begin
          ae_state     <= LOW_SET;
          almost_empty <= 1'b1;
        end
      end else begin
        if (occ > AE_CLR_LVL) begin
          ae_state     <= LOW_CLR;
          almost_empty <= 1'b0;
        end
      end

      if (af_state == HIGH_CLR) begin
        if (occ >= AF_SET_LVL) begin
          af_state    <= HIGH_SET;
          almost_full <= 1'b1;
        end
      end else begin
        if (occ < AF_CLR_LVL) begin
          af_state    <= HIGH_CLR;
          almost_full <= 1'b0;
        end
      end

      // Set has priority over clear so a same-edge offence is never lost.
      if (rd_req_i && empty)  underflow_err <= 1'b1;
      else if (clr_err_i)     underflow_err <= 1'b0;

      if (wr_req_i && full)   overflow_err  <= 1'b1;
      else if (clr_err_i)     overflow_err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_status_detector.sv
module tb_fifo_status_detector;

  localparam int N  = 16;
  localparam int AE = 2;
  localparam int AF = 14;
  localparam int HY = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic [15:0] e;
  logic        rd, wr, clr;
  logic [4:0]  count;
  logic        empty, full, ae_o, af_o, uf, of;

  // Small instance for the exhaustive sweep (N_CELLS=5, AE=1, AF=4, HYST=0)
  logic [4:0]  e2;
  logic        rd2, wr2, clr2;
  logic [2:0]  count2;
  logic        empty2, full2, ae2, af2, uf2, of2;

  fifo_status_detector dut (
    .clk(clk), .rst_n(rst_n), .e_i(e), .rd_req_i(rd), .wr_req_i(wr),
    .clr_err_i(clr), .count(count), .empty(empty), .full(full),
    .almost_empty(ae_o), .almost_full(af_o),
    .underflow_err(uf), .overflow_err(of)
  );

  fifo_status_detector #(.N_CELLS(5), .AE_THRESH(1), .AF_THRESH(4), .HYST(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .e_i(e2), .rd_req_i(rd2), .wr_req_i(wr2),
    .clr_err_i(clr2), .count(count2), .empty(empty2), .full(full2),
    .almost_empty(ae2), .almost_full(af2),
    .underflow_err(uf2), .overflow_err(of2)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural reference for the default instance
  int m_count;
  bit m_empty, m_full, m_ae, m_af, m_uf, m_of;

  typedef struct {
    int occ;
    bit rd, wr, clr;
    int x_count;
    bit x_ae, x_af, x_uf, x_of;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pat(input int k);
    logic [15:0] v;
    v = '1;
    for (int i = 0; i < k; i++) v[i] = 1'b0;
    return v;
  endfunction

  task automatic model_reset();
    m_count = 0; m_empty = 1; m_full = 0; m_ae = 1; m_af = 0; m_uf = 0; m_of = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"}, count, m_count);
    chk({tag, ".empty"}, empty, m_empty);
    chk({tag, ".full"},  full,  m_full);
    chk({tag, ".almost_empty"}, ae_o, m_ae);
    chk({tag, ".almost_full"},  af_o, m_af);
    chk({tag, ".underflow"}, uf, m_uf);
    chk({tag, ".overflow"},  of, m_of);
  endtask

  // One clock: the model takes the same inputs the DUT sees at the edge,
  // then outputs are compared 1 time unit after the edge.
  task automatic cycle(input string tag);
    int occ;
    @(posedge clk);
    occ = N - $countones(e);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (rd && m_empty) m_uf = 1; else if (clr) m_uf = 0;
      if (wr && m_full)  m_of = 1; else if (clr) m_of = 0;
      if (occ <= AE) m_ae = 1; else if (occ > AE + HY) m_ae = 0;
      if (occ >= AF) m_af = 1; else if (occ < AF - HY) m_af = 0;
      m_count = occ;
      m_empty = (occ == 0);
      m_full  = (occ == N);
    end
    #1;
    check_model(tag);
  endtask

  initial begin
    int k;
    int occ2;
    rst_n = 1'b0;
    e = '1; rd = 0; wr = 0; clr = 0;
    e2 = '1; rd2 = 0; wr2 = 0; clr2 = 0;
    model_reset();

    tbl[0]  = '{0,  1, 0, 0,  0,  1, 0, 1, 0};
    tbl[1]  = '{3,  0, 0, 0,  3,  1, 0, 1, 0};
    tbl[2]  = '{4,  0, 0, 0,  4,  0, 0, 1, 0};
    tbl[3]  = '{3,  0, 0, 0,  3,  0, 0, 1, 0};
    tbl[4]  = '{2,  0, 0, 0,  2,  1, 0, 1, 0};
    tbl[5]  = '{13, 0, 0, 0,  13, 0, 0, 1, 0};
    tbl[6]  = '{14, 0, 0, 0,  14, 0, 1, 1, 0};
    tbl[7]  = '{13, 0, 0, 0,  13, 0, 1, 1, 0};
    tbl[8]  = '{12, 0, 0, 0,  12, 0, 0, 1, 0};
    tbl[9]  = '{16, 0, 0, 0,  16, 0, 1, 1, 0};
    tbl[10] = '{16, 0, 1, 1,  16, 0, 1, 0, 1};
    tbl[11] = '{16, 0, 0, 1,  16, 0, 1, 0, 0};
    tbl[12] = '{16, 1, 1, 0,  16, 0, 1, 0, 1};
    tbl[13] = '{15, 0, 0, 1,  15, 0, 1, 0, 0};

    // Reset state while rst_n is held low
    #12;
    chk("rst.count", count, 0);
    chk("rst.empty", empty, 1);
    chk("rst.full", full, 0);
    chk("rst.almost_empty", ae_o, 1);
    chk("rst.almost_full", af_o, 0);
    chk("rst.underflow", uf, 0);
    chk("rst.overflow", of, 0);
    cycle("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    cycle("release");

    // Directed vectors: hysteresis, fill, error set/clear priority
    for (int i = 0; i < 14; i++) begin
      e = pat(tbl[i].occ); rd = tbl[i].rd; wr = tbl[i].wr; clr = tbl[i].clr;
      cycle("vec");
      chk($sformatf("vec%0d.count", i), count, tbl[i].x_count);
      chk($sformatf("vec%0d.empty", i), empty, tbl[i].x_count == 0);
      chk($sformatf("vec%0d.full", i), full, tbl[i].x_count == N);
      chk($sformatf("vec%0d.almost_empty", i), ae_o, tbl[i].x_ae);
      chk($sformatf("vec%0d.almost_full", i), af_o, tbl[i].x_af);
      chk($sformatf("vec%0d.underflow", i), uf, tbl[i].x_uf);
      chk($sformatf("vec%0d.overflow", i), of, tbl[i].x_of);
      rd = 0; wr = 0; clr = 0;
    end

    // Set both error flags, settle at occ=15, then async reset between edges
    e = pat(16); cycle("pre_full");
    wr = 1; cycle("set_of"); wr = 0;
    e = pat(0); cycle("pre_empty");
    rd = 1; cycle("set_uf"); rd = 0;
    e = pat(15); cycle("occ15");
    chk("mid.count15", count, 15);
    chk("mid.underflow_set", uf, 1);
    chk("mid.overflow_set", of, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async.count", count, 0);
    chk("async.empty", empty, 1);
    chk("async.full", full, 0);
    chk("async.almost_empty", ae_o, 1);
    chk("async.almost_full", af_o, 0);
    chk("async.underflow", uf, 0);
    chk("async.overflow", of, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_reset");

    // Randomised stimulus against the reference model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3, 0) == 0) begin
        e = 16'($urandom);
      end else begin
        k = $urandom_range(16, 0);
        e = '1;
        if (k == 16) e = '0;
        else repeat (k) e[$urandom_range(15, 0)] = 1'b0;
      end
      rd  = 1'($urandom_range(1, 0));
      wr  = 1'($urandom_range(1, 0));
      clr = ($urandom_range(7, 0) == 0);
      cycle("rand");
    end
    rd = 0; wr = 0; clr = 0;

    // Exhaustive sweep on the small instance: HYST=0 means plain compares
    for (int p = 0; p < 32; p++) begin
      e2 = 5'(p);
      cycle("sweep_main");
      occ2 = 5 - $countones(5'(p));
      chk($sformatf("sw%0d.count", p), count2, occ2);
      chk($sformatf("sw%0d.empty", p), empty2, occ2 == 0);
      chk($sformatf("sw%0d.full", p), full2, occ2 == 5);
      chk($sformatf("sw%0d.almost_empty", p), ae2, occ2 <= 1);
      chk($sformatf("sw%0d.almost_full", p), af2, occ2 >= 4);
      chk($sformatf("sw%0d.errs", p), {uf2, of2}, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
